instruction_fetch: RTL

Instruction fetch stage. Holds the architectural fetch PC, issues one word request at a time to the instruction cache, and queries the 2-bit branch predictor with the fetch PC. It computes the next PC (static for JAL, predicted for B-type) and delivers one instruction per handshake to the issue stage. RoB flushes redirect it.

---
 rtl/instruction_fetch.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the fetch PC, issues one I-cache word request at a time,
// predicts JAL/B-type targets and hands one instruction per handshake to issue.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_en,
  input  logic [31:0] flush_PC,
  output logic        icache_req_valid,
  output logic [31:0] icache_req_addr,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_inst,
  output logic [31:0] bp_query_PC,
  input  logic        bp_result,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_PC,
  output logic        inst_pred_taken,
  input  logic        issue_ready
);

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef enum logic [1:0] {IDLE, WAIT, DROP, STALL} state_t;

  state_t             state, state_nxt;
  logic        [31:0] pc, pc_nxt;
  logic        [31:0] target;
  logic signed [31:0] imm;
  logic               pred;
  logic               load;
  logic               out_free;
  logic               xfer;
  logic               is_jalr;

  function automatic logic signed [31:0] b_imm(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] j_imm(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  assign icache_req_valid = (state == WAIT);
  assign icache_req_addr  = pc;
  assign bp_query_PC      = pc;

  // Next-PC / prediction for the word arriving from the cache
  always_comb begin
    imm     = '0;
    target  = pc + 32'd4;
    pred    = 1'b0;
    is_jalr = (icache_resp_inst[6:0] == OP_JALR);
    case (icache_resp_inst[6:0])
      OP_JAL: begin
        imm    = j_imm(icache_resp_inst);
        target = pc + $unsigned(imm);
        pred   = 1'b1;
      end
      OP_BR: begin
        imm = b_imm(icache_resp_inst);
        if (bp_result) begin
          target = pc + $unsigned(imm);
          pred   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    out_free  = !inst_valid || issue_ready;
    xfer      = inst_valid && issue_ready;
    state_nxt = state;
    pc_nxt    = pc;
    load      = 1'b0;
    case (state)
      IDLE: if (out_free) state_nxt = WAIT;
      WAIT: begin
        if (icache_resp_valid) begin
          load = 1'b1;
          if (is_jalr) begin
            state_nxt = STALL;
          end else begin
            pc_nxt    = target;
            state_nxt = IDLE;
          end
        end
      end
      DROP:    if (icache_resp_valid) state_nxt = IDLE;
      STALL:   ;
      default: state_nxt = IDLE;
    endcase
    // A redirect overrides everything; an in-flight request becomes a drop
    if (flush_en) begin
      pc_nxt = flush_PC;
      load   = 1'b0;
      case (state)
        WAIT:    state_nxt = icache_resp_valid ? IDLE : DROP;
        DROP:    state_nxt = DROP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Fetch state and output register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      inst_valid      <= 1'b0;
      inst_out        <= '0;
      inst_PC         <= '0;
      inst_pred_taken <= 1'b0;
    end else if (rdy_in) begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (flush_en) begin
        inst_valid <= 1'b0;
      end else if (load) begin
        inst_valid      <= 1'b1;
        inst_out        <= icache_resp_inst;
        inst_PC         <= pc;
        inst_pred_taken <= pred;
      end else if (xfer) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule
